// File: rtl/hk628_input_cond_if.sv
// ============================================================================
// Module   : hk628_input_cond_if
// Brief    : Button bus between the joystick word and the HK-628 conditioner.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hk628_input_cond_if #(
  parameter int NBTN = 9
);
  logic [NBTN-1:0] joy_raw;
  logic [7:0]      btn;
  logic            low_batt_btn;
  logic [NBTN-1:0] press_pulse;
  logic [3:0]      active_idx;

  // slave is the conditioner itself; master is whoever supplies raw buttons
  modport slave (
    input  joy_raw,
    output btn,
    output low_batt_btn,
    output press_pulse,
    output active_idx
  );

  modport master (
    output joy_raw,
    input  btn,
    input  low_batt_btn,
    input  press_pulse,
    input  active_idx
  );
endinterface

`default_nettype wire

// File: rtl/hk628_input_cond.sv
// ============================================================================
// Module   : hk628_input_cond
// Brief    : Per-button sync + debounce + press pulses, and last-pressed tracking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hk628_input_cond #(
  parameter int NBTN      = 9,
  parameter int DB_CYCLES = 65536
) (
  input  wire logic          clk_sys,
  input  wire logic          reset,
  hk628_input_cond_if.slave  bus
);

  localparam int             c_CW       = $clog2(DB_CYCLES + 1);
  localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(DB_CYCLES - 1);
  localparam logic [3:0]     c_NONE     = 4'hF;

  if (NBTN != 9) begin : g_bad_nbtn
    $error("hk628_input_cond: NBTN must be 9");
  end
  if (DB_CYCLES < 1 || DB_CYCLES > (1 << 20)) begin : g_bad_db
    $error("hk628_input_cond: DB_CYCLES must be in 1..2^20");
  end

  logic [NBTN-1:0] r_s1;
  logic [NBTN-1:0] r_s2;
  logic [NBTN-1:0] w_st;
  logic [NBTN-1:0] w_pulse;
  logic [3:0]      r_active;
  logic [3:0]      w_active_nxt;
  logic [3:0]      w_press_idx;
  logic [3:0]      w_held_idx;
  logic            w_act_fell;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= bus.joy_raw;
      r_s2 <= r_s1;
    end
  end

  for (genvar i = 0; i < NBTN; i++) begin : g_bit
    logic [c_CW-1:0] r_cnt;
    logic            r_st;
    logic            r_pulse;

    // Counter clears whenever the input agrees with st, so it can never wrap
    always_ff @(posedge clk_sys) begin
      if (reset) begin
        r_cnt   <= '0;
        r_st    <= 1'b0;
        r_pulse <= 1'b0;
      end else begin
        r_pulse <= 1'b0;
        if (r_s2[i] == r_st) begin
          r_cnt <= '0;
        end else if (r_cnt == c_CNT_LAST) begin
          r_st    <= r_s2[i];
          r_cnt   <= '0;
          r_pulse <= r_s2[i];
        end else begin
          r_cnt <= r_cnt + c_CW'(1);
        end
      end
    end

    assign w_st[i]    = r_st;
    assign w_pulse[i] = r_pulse;
  end

  always_comb begin
    w_press_idx = c_NONE;
    w_held_idx  = c_NONE;
    w_act_fell  = 1'b0;
    for (int k = NBTN - 1; k >= 0; k--) begin
      if (w_pulse[k]) w_press_idx = 4'(k);
      if (w_st[k])    w_held_idx  = 4'(k);
    end
    for (int k = 0; k < NBTN; k++) begin
      if (r_active == 4'(k) && !w_st[k]) w_act_fell = 1'b1;
    end
    w_active_nxt = r_active;
    if (|w_pulse)        w_active_nxt = w_press_idx;
    else if (w_act_fell) w_active_nxt = w_held_idx;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) r_active <= c_NONE;
    else       r_active <= w_active_nxt;
  end

  assign bus.btn          = w_st[7:0];
  assign bus.low_batt_btn = w_st[8];
  assign bus.press_pulse  = w_pulse;
  assign bus.active_idx   = r_active;

endmodule

`default_nettype wire

// File: tb/tb_hk628_input_cond.sv
// ============================================================================
// Module   : tb_hk628_input_cond
// Brief    : Directed self-checking bench for hk628_input_cond, DB_CYCLES = 4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hk628_input_cond;

  localparam int c_DB = 4;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  hk628_input_cond_if #(.NBTN(9)) bus ();

  hk628_input_cond #(.NBTN(9), .DB_CYCLES(c_DB)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on falling edges only
  task automatic wait_n(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  logic seen;

  initial begin
    bus.joy_raw = '0;
    wait_n(3);
    chk("rst_btn",    32'(bus.btn),          32'h0);
    chk("rst_lb",     32'(bus.low_batt_btn), 32'h0);
    chk("rst_pulse",  32'(bus.press_pulse),  32'h0);
    chk("rst_active", 32'(bus.active_idx),   32'hF);
    reset = 1'b0;

    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_sys);
      if (bus.btn != 0 || bus.low_batt_btn || bus.press_pulse != 0 || bus.active_idx != 4'hF)
        seen = 1'b1;
    end
    chk("idle_quiet", 32'(seen), 32'h0);

    // Single press: st rises on the 6th edge counting the one that samples joy_raw
    bus.joy_raw = 9'h004;
    wait_n(5);
    chk("p2_early",  32'(bus.btn),         32'h00);
    wait_n(1);
    chk("p2_btn",    32'(bus.btn),         32'h04);
    chk("p2_pulse",  32'(bus.press_pulse), 32'h004);
    chk("p2_act_lag",32'(bus.active_idx),  32'hF);
    wait_n(1);
    chk("p2_pulse1", 32'(bus.press_pulse), 32'h000);
    chk("p2_active", 32'(bus.active_idx),  32'h2);
    bus.joy_raw = 9'h000;
    wait_n(5);
    chk("r2_early",  32'(bus.btn),         32'h04);
    wait_n(1);
    chk("r2_btn",    32'(bus.btn),         32'h00);
    chk("r2_pulse",  32'(bus.press_pulse), 32'h000);
    chk("r2_act_lag",32'(bus.active_idx),  32'h2);
    wait_n(1);
    chk("r2_active", 32'(bus.active_idx),  32'hF);

    // Glitchy bit 5: three samples high never completes a four-cycle count
    seen = 1'b0;
    for (int r = 0; r < 10; r++) begin
      bus.joy_raw = 9'h020;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk_sys);
        if (bus.btn[5] || bus.press_pulse != 0) seen = 1'b1;
      end
      bus.joy_raw = 9'h000;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk_sys);
        if (bus.btn[5] || bus.press_pulse != 0) seen = 1'b1;
      end
    end
    wait_n(8);
    if (bus.btn[5] || bus.press_pulse != 0) seen = 1'b1;
    chk("glitch5", 32'(seen), 32'h0);

    // Simultaneous press of 7 and 1 resolves to 1
    bus.joy_raw = 9'h082;
    wait_n(6);
    chk("p71_pulse",  32'(bus.press_pulse), 32'h082);
    chk("p71_btn",    32'(bus.btn),         32'h82);
    wait_n(1);
    chk("p71_active", 32'(bus.active_idx),  32'h1);
    bus.joy_raw = 9'h080;
    wait_n(6);
    chk("r1_btn",     32'(bus.btn),         32'h80);
    chk("r1_act_lag", 32'(bus.active_idx),  32'h1);
    wait_n(1);
    chk("r1_active",  32'(bus.active_idx),  32'h7);
    bus.joy_raw = 9'h000;
    wait_n(8);
    chk("r7_active",  32'(bus.active_idx),  32'hF);

    // Last pressed wins, then fall back to the remaining held button
    bus.joy_raw = 9'h001;
    wait_n(7);
    chk("p0_active",  32'(bus.active_idx),  32'h0);
    bus.joy_raw = 9'h101;
    wait_n(6);
    chk("p8_pulse",   32'(bus.press_pulse), 32'h100);
    chk("p8_lb",      32'(bus.low_batt_btn),32'h1);
    wait_n(1);
    chk("p8_active",  32'(bus.active_idx),  32'h8);
    bus.joy_raw = 9'h001;
    wait_n(7);
    chk("r8_lb",      32'(bus.low_batt_btn),32'h0);
    chk("r8_active",  32'(bus.active_idx),  32'h0);
    bus.joy_raw = 9'h000;
    wait_n(8);
    chk("r0_active",  32'(bus.active_idx),  32'hF);

    // Reset in the middle of a debounce discards the partial count
    bus.joy_raw = 9'h008;
    wait_n(3);
    reset = 1'b1;
    wait_n(2);
    chk("mr_btn",    32'(bus.btn),         32'h00);
    chk("mr_pulse",  32'(bus.press_pulse), 32'h000);
    chk("mr_active", 32'(bus.active_idx),  32'hF);
    reset = 1'b0;
    wait_n(5);
    chk("mr_early",  32'(bus.btn),         32'h00);
    wait_n(1);
    chk("mr_btn3",   32'(bus.btn),         32'h08);
    chk("mr_pulse3", 32'(bus.press_pulse), 32'h008);
    wait_n(1);
    chk("mr_active3",32'(bus.active_idx),  32'h3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hk628_input_cond.md
Name: hk628_input_cond

Overview:
- Conditions the raw controller button vector before it reaches the HK-628 sound core.
- Per button: synchroniser, debounce, then rising-edge press pulses.
- Also tracks which button was pressed last, so the core and the OSD can see the single active sound source.
- Sits between the framework's joystick_0 word and the core's btn[7:0] / low_batt_btn inputs, in the clk_sys domain.

Parameters:
- NBTN, 9, number of buttons conditioned. Bits 0-7 are sound buttons; bit 8 is low-battery FX. Only 9 is supported.
- DB_CYCLES, 65536, consecutive clk_sys cycles a synchronised input must differ from the debounced state before that state flips. Legal range 1..2^20. Out-of-range values must fail elaboration.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high reset
- joy_raw  in  9  raw buttons, joystick_0[8:0]; 1 = pressed
- btn  out  8  debounced level, buttons 1-8
- low_batt_btn  out  1  debounced level, button 9
- press_pulse  out  9  one-cycle pulse on each debounced 0->1 transition
- active_idx  out  4  index 0..8 of the current active button; 4'hF = none

Behaviour:
- Reset (synchronous, active-high): sync flops, debounced state st, counters, press_pulse and btn/low_batt_btn all clear to 0; active_idx = 4'hF. Reset dominates every other event in the same cycle.
- Synchroniser: two flops per bit, s1 <= joy_raw, s2 <= s1. No combinational path from joy_raw to any output.
- Debounce, per bit i, with a counter cnt[i] of width clog2(DB_CYCLES+1):
  - If s2[i] == st[i]: cnt[i] <= 0.
  - Else if cnt[i] == DB_CYCLES-1: st[i] <= s2[i], cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
- Latency: a clean raw edge appears on st exactly DB_CYCLES+2 clock edges after the edge that first samples it.
- Glitches: any glitch that returns to st[i] before the count completes restarts the counter and causes no output change. The counter must never wrap.
- Outputs: btn = st[7:0] and low_batt_btn = st[8], driven directly from registers.
- press_pulse[i]: high for exactly the one cycle in which st[i] first reads 1. Releases produce no pulse. A re-press needs a full release debounce followed by a full press debounce.
- active_idx is registered and updates one cycle after the press_pulse/st change that causes it. Rules in priority order:
  1. Any press_pulse bits set: active_idx <= lowest set index. Simultaneous presses resolve to the lowest index.
  2. Else, if st[active_idx] has fallen to 0: active_idx <= lowest index with st = 1, or 4'hF if none are held.
  3. Else: hold.
- A press of a different button overrides the current active button even while the old one is still held ("last pressed wins").
- Reset mid-debounce: the partial count is discarded. A button still held when reset deasserts is treated as a fresh press: st rises DB_CYCLES+2 edges later, with a pulse.
- All 9 bits are processed independently and identically. There is no cross-channel interaction except in active_idx.

Test Plan (DB_CYCLES=4):
- Reset, then hold joy_raw=0 for 20 cycles -> btn=0, low_batt_btn=0, press_pulse=0, active_idx=4'hF throughout.
- joy_raw[2] 0->1 held -> btn[2] rises exactly 6 edges after first sampling; press_pulse=9'h004 for 1 cycle; active_idx=2 on the following cycle. Release -> btn[2] falls 6 edges later with no pulse; active_idx=4'hF one cycle after that.
- joy_raw[5] pulses high for 3 cycles, then low; repeat 10 times -> btn[5] never rises, press_pulse never set.
- joy_raw[7] and joy_raw[1] rise on the same edge -> press_pulse=9'h082 for one cycle; active_idx=1. Release bit 1 only -> active_idx=7.
- Hold bit 0, then press bit 8 -> active_idx goes 0 then 8 and low_batt_btn=1. Release bit 8 -> active_idx returns to 0.
- Hold joy_raw[3] and assert reset for 2 cycles midway through its debounce -> all outputs clear during reset; btn[3] rises 6 edges after reset deasserts, with press_pulse[3].
